// File: rtl/fnn_pkg.sv
// Shared types and sizes for the output-layer score path (packer and argmax).
package fnn_pkg;

    localparam int unsigned NUM_OUT = 10;
    localparam int unsigned DATA_W  = 8;
    localparam int unsigned VEC_W   = NUM_OUT * DATA_W;
    localparam int unsigned CNT_W   = $clog2(NUM_OUT);

    typedef logic [DATA_W-1:0] score_t;
    typedef logic [VEC_W-1:0]  score_vec_t;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } pack_state_t;

endpackage

// File: rtl/score_packer_if.sv
// Score stream in, packed score vector out. The master modport is the packer side.
interface score_packer_if;
    import fnn_pkg::*;

    logic       in_valid;
    logic       in_ready;
    score_t     in_data;
    logic       in_last;
    logic       out_valid;
    logic       out_ready;
    score_vec_t out_vec;
    logic       frame_err;

    modport master (
        input  in_valid, in_data, in_last, out_ready,
        output in_ready, out_valid, out_vec, frame_err
    );

    modport slave (
        output in_valid, in_data, in_last, out_ready,
        input  in_ready, out_valid, out_vec, frame_err
    );
endinterface

// File: rtl/score_packer.sv
// Packs NUM_OUT serial score beats into one vector for the argmax stage.
// Define SCORE_PACKER_RELU_EN to clamp negative (two's-complement) scores to zero.
module score_packer
    import fnn_pkg::*;
(
    input  logic           clk,
    input  logic           rst_n,
    score_packer_if.master bus
);

    pack_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    score_vec_t       vec_q, vec_d;
    logic             err_q, err_d;
    score_t           beat;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= COLLECT;
            cnt_q   <= '0;
            vec_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            vec_q   <= vec_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        vec_d   = vec_q;
        err_d   = 1'b0;
`ifdef SCORE_PACKER_RELU_EN
        beat    = bus.in_data[DATA_W-1] ? '0 : bus.in_data;
`else
        beat    = bus.in_data;
`endif
        case (state_q)
            COLLECT: begin
                if (bus.in_valid) begin
                    for (int k = 0; k < int'(NUM_OUT); k++) begin
                        if (cnt_q == CNT_W'(k)) vec_d[k*DATA_W +: DATA_W] = beat;
                    end
                    // Last slot always emits; a missing in_last flags a long frame.
                    if (cnt_q == CNT_W'(NUM_OUT - 1)) begin
                        cnt_d   = '0;
                        state_d = HOLD;
                        err_d   = ~bus.in_last;
                    end else if (bus.in_last) begin
                        cnt_d = '0;
                        err_d = 1'b1;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            HOLD: begin
                if (bus.out_ready) state_d = COLLECT;
            end
            default: state_d = COLLECT;
        endcase
    end

    assign bus.in_ready  = (state_q == COLLECT);
    assign bus.out_valid = (state_q == HOLD);
    assign bus.out_vec   = vec_q;
    assign bus.frame_err = err_q;

endmodule

// File: tb/tb_score_packer.sv
// Directed self-checking bench for score_packer (both RELU and raw builds).
module tb_score_packer;
    import fnn_pkg::*;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    score_packer_if bus ();

    score_packer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One accepted beat per call; returns #1 after the accepting edge.
    task automatic send_beat(input logic [7:0] d, input logic last);
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: out_valid=%b in_ready=%b frame_err=%b want 0 1 0",
                     bus.out_valid, bus.in_ready, bus.frame_err);
        end
        checks++;
        if (bus.out_vec !== 80'h0) begin
            errors++;
            $display("FAIL reset_vec: got %h want 0", bus.out_vec);
        end
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        for (int k = 1; k <= 9; k++) send_beat(8'(k * 10), 1'b0);
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL basic_early_valid: got %b want 0", bus.out_valid);
        end
        send_beat(8'd100, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL basic_valid: out_valid=%b in_ready=%b want 1 0", bus.out_valid, bus.in_ready);
        end
        checks++;
        if (bus.out_vec !== 80'h645A50463C32281E140A) begin
            errors++;
            $display("FAIL basic_vec: got %h want 645a50463c32281e140a", bus.out_vec);
        end
        checks++;
        if (bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL basic_err: got %b want 0", bus.frame_err);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL basic_release: out_valid=%b in_ready=%b want 0 1", bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        for (int k = 1; k <= 10; k++) send_beat(8'(k * 10), k == 10);
        for (int c = 0; c < 5; c++) begin
            bus.in_valid = 1'b1;
            bus.in_data  = 8'hEE;
            bus.in_last  = 1'b1;
            checks++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 ||
                bus.out_vec !== 80'h645A50463C32281E140A) begin
                errors++;
                $display("FAIL bp_hold[%0d]: out_valid=%b in_ready=%b vec=%h", c,
                         bus.out_valid, bus.in_ready, bus.out_vec);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid  = 1'b0;
        bus.in_last   = 1'b0;
        checks++;
        if (bus.frame_err !== 1'b0 || bus.out_vec !== 80'h645A50463C32281E140A) begin
            errors++;
            $display("FAIL bp_no_accept: frame_err=%b vec=%h", bus.frame_err, bus.out_vec);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: in_ready=%b out_valid=%b want 1 0", bus.in_ready, bus.out_valid);
        end
    endtask

    task automatic test_short_frame();
        for (int k = 1; k <= 4; k++) send_beat(8'(k), k == 4);
        checks++;
        if (bus.frame_err !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL short_err: frame_err=%b out_valid=%b want 1 0", bus.frame_err, bus.out_valid);
        end
        for (int k = 1; k <= 9; k++) begin
            send_beat(8'h09, 1'b0);
            if (k == 1) begin
                checks++;
                if (bus.frame_err !== 1'b0 || bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL short_pulse: frame_err=%b out_valid=%b want 0 0",
                             bus.frame_err, bus.out_valid);
                end
            end
        end
        send_beat(8'h09, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_vec !== {10{8'h09}} || bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL short_next: out_valid=%b vec=%h frame_err=%b", bus.out_valid, bus.out_vec,
                     bus.frame_err);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_long_frame();
        for (int k = 1; k <= 10; k++) send_beat(8'h55, 1'b0);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.frame_err !== 1'b1) begin
            errors++;
            $display("FAIL long_flags: out_valid=%b frame_err=%b want 1 1", bus.out_valid, bus.frame_err);
        end
        checks++;
        if (bus.out_vec !== {10{8'h55}}) begin
            errors++;
            $display("FAIL long_vec: got %h want all 55", bus.out_vec);
        end
        @(posedge clk);
        #1;
        checks++;
        if (bus.frame_err !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL long_after: frame_err=%b out_valid=%b want 0 0", bus.frame_err, bus.out_valid);
        end
    endtask

    task automatic test_reset_mid_frame();
        for (int k = 1; k <= 6; k++) send_beat(8'hA0, 1'b0);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_vec !== 80'h0 ||
            bus.frame_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst: out_valid=%b in_ready=%b frame_err=%b vec=%h", bus.out_valid,
                     bus.in_ready, bus.frame_err, bus.out_vec);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) send_beat(8'(8'h30 + k), k == 9);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_vec !== 80'h39383736353433323130) begin
            errors++;
            $display("FAIL midrst_frame: out_valid=%b vec=%h want 1 39383736353433323130",
                     bus.out_valid, bus.out_vec);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_relu();
        logic [79:0] exp_vec;
`ifdef SCORE_PACKER_RELU_EN
        exp_vec = 80'h00000000000000007F00;
`else
        exp_vec = 80'h00000000000000807FF3;
`endif
        send_beat(8'hF3, 1'b0);
        send_beat(8'h7F, 1'b0);
        send_beat(8'h80, 1'b0);
        for (int k = 3; k < 10; k++) send_beat(8'h00, k == 9);
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_vec !== exp_vec) begin
            errors++;
            $display("FAIL relu_vec: out_valid=%b vec=%h want %h", bus.out_valid, bus.out_vec, exp_vec);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        test_basic();
        test_backpressure();
        test_short_frame();
        test_long_frame();
        test_reset_mid_frame();
        test_relu();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
